// File: rtl/id_pkg.sv
// Shared types and constants for the ID stage: uop classes, LA32R opcode fields, INE ecode.
package id_pkg;

   localparam int FETCH_BUS_W = 64;
   localparam logic [5:0] ECODE_INE = 6'h0D;

   typedef enum logic [3:0] {
      UOP_NOP     = 4'h0,
      UOP_ADD     = 4'h1,
      UOP_SUB     = 4'h2,
      UOP_ADDI    = 4'h3,
      UOP_LU12I   = 4'h4,
      UOP_LD      = 4'h5,
      UOP_ST      = 4'h6,
      UOP_JIRL    = 4'h7,
      UOP_B       = 4'h8,
      UOP_BL      = 4'h9,
      UOP_BEQ     = 4'hA,
      UOP_BNE     = 4'hB,
      UOP_INVALID = 4'hF
   } uop_t;

   localparam logic [16:0] OP17_ADD   = 17'h00020;
   localparam logic [16:0] OP17_SUB   = 17'h00022;
   localparam logic [9:0]  OP10_ADDI  = 10'h00a;
   localparam logic [6:0]  OP7_LU12I  = 7'h0a;
   localparam logic [9:0]  OP10_LD    = 10'h0a2;
   localparam logic [9:0]  OP10_ST    = 10'h0a6;
   localparam logic [5:0]  OP6_JIRL   = 6'h13;
   localparam logic [5:0]  OP6_B      = 6'h14;
   localparam logic [5:0]  OP6_BL     = 6'h15;
   localparam logic [5:0]  OP6_BEQ    = 6'h16;
   localparam logic [5:0]  OP6_BNE    = 6'h17;

endpackage

// File: rtl/la32_decoder.sv
// Combinational LA32R-subset decoder: raw instruction -> uop class, register fields, immediate.
module la32_decoder
   import id_pkg::*;
(
   input  logic [31:0] inst,
   output uop_t        uop,
   output logic [4:0]  rd,
   output logic [4:0]  rj,
   output logic [4:0]  rk,
   output logic [31:0] imm,
   output logic        rf_we,
   output logic        ine
);

   logic writes;

   always_comb begin
      uop    = UOP_INVALID;
      rd     = inst[4:0];
      rj     = inst[9:5];
      rk     = inst[14:10];
      imm    = '0;
      writes = 1'b0;
      if (inst[31:15] == OP17_ADD) begin
         uop    = UOP_ADD;
         writes = 1'b1;
      end else if (inst[31:15] == OP17_SUB) begin
         uop    = UOP_SUB;
         writes = 1'b1;
      end else if (inst[31:22] == OP10_ADDI) begin
         uop    = UOP_ADDI;
         imm    = {{20{inst[21]}}, inst[21:10]};
         writes = 1'b1;
      end else if (inst[31:25] == OP7_LU12I) begin
         uop    = UOP_LU12I;
         imm    = {inst[24:5], 12'b0};
         writes = 1'b1;
      end else if (inst[31:22] == OP10_LD) begin
         uop    = UOP_LD;
         imm    = {{20{inst[21]}}, inst[21:10]};
         writes = 1'b1;
      end else if (inst[31:22] == OP10_ST) begin
         uop    = UOP_ST;
         imm    = {{20{inst[21]}}, inst[21:10]};
      end else if (inst[31:26] == OP6_JIRL) begin
         uop    = UOP_JIRL;
         imm    = {{14{inst[25]}}, inst[25:10], 2'b00};
         writes = 1'b1;
      end else if (inst[31:26] == OP6_BEQ) begin
         uop    = UOP_BEQ;
         imm    = {{14{inst[25]}}, inst[25:10], 2'b00};
      end else if (inst[31:26] == OP6_BNE) begin
         uop    = UOP_BNE;
         imm    = {{14{inst[25]}}, inst[25:10], 2'b00};
      end else if (inst[31:26] == OP6_B) begin
         uop    = UOP_B;
         imm    = {{4{inst[9]}}, inst[9:0], inst[25:10], 2'b00};
      end else if (inst[31:26] == OP6_BL) begin
         uop    = UOP_BL;
         rd     = 5'd1;
         imm    = {{4{inst[9]}}, inst[9:0], inst[25:10], 2'b00};
         writes = 1'b1;
      end
      // writes to r0 are architecturally discarded, so never request them
      rf_we = writes & (rd != '0);
      ine   = (uop == UOP_INVALID);
   end

endmodule

// File: rtl/id_decode_buffer.sv
// IF->EXE skid FIFO with head decode. Optional `ID_INE_EXCP_EN raises out_excp on invalid
// instructions; otherwise they decode as NOP.
module id_decode_buffer
   import id_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [FETCH_BUS_W-1:0] in_bus,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [31:0]            out_pc,
   output logic [31:0]            out_inst,
   output logic [3:0]             out_uop,
   output logic [4:0]             out_rd,
   output logic [4:0]             out_rj,
   output logic [4:0]             out_rk,
   output logic [31:0]            out_imm,
   output logic                   out_rf_we,
   output logic                   out_excp
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

   logic [FETCH_BUS_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]       rd_ptr, wr_ptr;
   logic [PTR_W:0]         count;
   logic                   push, pop;
   logic [FETCH_BUS_W-1:0] head;
   uop_t                   dec_uop;
   logic                   dec_ine;

   assign in_ready  = (count != FULL);
   assign out_valid = (count != '0);
   assign push      = in_valid & in_ready & ~flush;
   assign pop       = out_valid & out_ready & ~flush;

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         count  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_bus;
   end

   assign head     = mem[rd_ptr];
   assign out_pc   = head[63:32];
   assign out_inst = head[31:0];

   la32_decoder u_dec (
      .inst  (head[31:0]),
      .uop   (dec_uop),
      .rd    (out_rd),
      .rj    (out_rj),
      .rk    (out_rk),
      .imm   (out_imm),
      .rf_we (out_rf_we),
      .ine   (dec_ine)
   );

`ifdef ID_INE_EXCP_EN
   assign out_uop  = dec_uop;
   assign out_excp = dec_ine & out_valid;
`else
   assign out_uop  = dec_ine ? UOP_NOP : dec_uop;
   assign out_excp = 1'b0;
`endif

endmodule
